shift_deserializer: RTL and testbench

Serial-to-parallel receiver paired with the ALU shift register. It collects a WIDTH-bit word one bit at a time from a serial stream, such as the shifter's FLAG output driven by repeated LSH or RSH. It reassembles the word in either bit order and presents it on a valid/ready output handshake. It reconstructs words the shifter serialises, for loopback checks and for datapath moves between registers.

---
 rtl/shift_deserializer_if.sv | 26 ++
 rtl/shift_deserializer.sv | 146 ++++++++++++++
 tb/tb_shift_deserializer.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/shift_deserializer_if.sv
// Serial input stream and parallel output handshake for the shift deserializer.
interface shift_deserializer_if #(
    parameter int unsigned WIDTH = 4
);
    logic             sin_i;
    logic             sin_valid_i;
    logic             dir_i;
    logic             clear_i;
    logic             out_ready_i;
    logic [WIDTH-1:0] out_o;
    logic             out_valid_o;
    logic             busy_o;
    logic             overrun_o;

    // Receiver side
    modport slave (
        input  sin_i, sin_valid_i, dir_i, clear_i, out_ready_i,
        output out_o, out_valid_o, busy_o, overrun_o
    );

    // Producer/consumer side
    modport master (
        output sin_i, sin_valid_i, dir_i, clear_i, out_ready_i,
        input  out_o, out_valid_o, busy_o, overrun_o
    );
endinterface

// File: rtl/shift_deserializer.sv
// Serial-to-parallel receiver: collects WIDTH bits in either order and
// presents the assembled word on a valid/ready handshake.
module shift_deserializer #(
    parameter int unsigned WIDTH = 4
) (
    input logic               clk,
    input logic               rst_n,
    shift_deserializer_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   sr_q, sr_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic               dir_q, dir_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;
    logic               overrun_q, overrun_d;

    logic [WIDTH-1:0]   shift_msb_c;
    logic [WIDTH-1:0]   shift_lsb_c;
    logic               last_bit_c;

    // Candidate shift results for both bit orders and end-of-word detect
    always_comb begin
        shift_msb_c = {sr_q[WIDTH-2:0], bus.sin_i};
        shift_lsb_c = {bus.sin_i, sr_q[WIDTH-1:1]};
        last_bit_c  = (cnt_q == CNT_W'(WIDTH - 1));
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; clear overrides every transition
    always_comb begin
        state_d = state_q;
        if (bus.clear_i) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.sin_valid_i) state_d = COLLECT;
                end
                COLLECT: begin
                    if (bus.sin_valid_i && last_bit_c) state_d = HOLD;
                end
                HOLD: begin
                    if (bus.out_ready_i) state_d = bus.sin_valid_i ? COLLECT : IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Datapath next values; a new word latches DIR from the input, mid-word uses dir_q
    always_comb begin
        cnt_d       = cnt_q;
        sr_d        = sr_q;
        out_d       = out_q;
        dir_d       = dir_q;
        out_valid_d = out_valid_q;
        overrun_d   = overrun_q;
        if (bus.clear_i) begin
            cnt_d       = '0;
            sr_d        = '0;
            out_valid_d = 1'b0;
            overrun_d   = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.sin_valid_i) begin
                        dir_d = bus.dir_i;
                        sr_d  = bus.dir_i ? shift_lsb_c : shift_msb_c;
                        cnt_d = CNT_W'(1);
                    end
                end
                COLLECT: begin
                    if (bus.sin_valid_i) begin
                        sr_d = dir_q ? shift_lsb_c : shift_msb_c;
                        if (last_bit_c) begin
                            out_d       = sr_d;
                            out_valid_d = 1'b1;
                            cnt_d       = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (bus.out_ready_i) begin
                        out_valid_d = 1'b0;
                        if (bus.sin_valid_i) begin
                            dir_d = bus.dir_i;
                            sr_d  = bus.dir_i ? shift_lsb_c : shift_msb_c;
                            cnt_d = CNT_W'(1);
                        end
                    end else if (bus.sin_valid_i) begin
                        overrun_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
        busy_d = (state_d == COLLECT);
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            sr_q        <= '0;
            out_q       <= '0;
            dir_q       <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            sr_q        <= sr_d;
            out_q       <= out_d;
            dir_q       <= dir_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bus.out_o       = out_q;
    assign bus.out_valid_o = out_valid_q;
    assign bus.busy_o      = busy_q;
    assign bus.overrun_o   = overrun_q;

endmodule

// File: tb/tb_shift_deserializer.sv
// Randomised and directed bench for shift_deserializer with a bit-queue reference model.
module tb_shift_deserializer;
    localparam int unsigned W = 4;

    logic clk;
    logic rst_n;

    shift_deserializer_if #(.WIDTH(W)) bus ();

    shift_deserializer #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: bits of the word in progress, in arrival order
    bit           m_bits[$];
    bit           m_dir;
    bit           m_held;
    bit           m_overrun;
    int unsigned  m_out;

    function automatic int unsigned assemble();
        int unsigned v = 0;
        for (int i = 0; i < int'(W); i++) begin
            if (m_dir) v = v | (int'(m_bits[i]) << i);
            else       v = v | (int'(m_bits[i]) << (int'(W) - 1 - i));
        end
        return v;
    endfunction

    task automatic model_reset();
        m_bits.delete();
        m_dir     = 1'b0;
        m_held    = 1'b0;
        m_overrun = 1'b0;
        m_out     = 0;
    endtask

    task automatic model_edge();
        if (bus.clear_i) begin
            m_bits.delete();
            m_held    = 1'b0;
            m_overrun = 1'b0;
        end else if (m_held) begin
            if (bus.out_ready_i) begin
                m_held = 1'b0;
                if (bus.sin_valid_i) begin
                    m_dir = bus.dir_i;
                    m_bits.push_back(bus.sin_i);
                end
            end else if (bus.sin_valid_i) begin
                m_overrun = 1'b1;
            end
        end else if (bus.sin_valid_i) begin
            if (m_bits.size() == 0) m_dir = bus.dir_i;
            m_bits.push_back(bus.sin_i);
            if (m_bits.size() == int'(W)) begin
                m_out  = assemble();
                m_held = 1'b1;
                m_bits.delete();
            end
        end
    endtask

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        chk("out",       int'(bus.out_o),       m_out);
        chk("out_valid", int'(bus.out_valid_o), int'(m_held));
        chk("busy",      int'(bus.busy_o),      int'(m_bits.size() > 0));
        chk("overrun",   int'(bus.overrun_o),   int'(m_overrun));
    endtask

    // One clock edge: model sees the same inputs as the DUT, compare just after
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_model();
    endtask

    task automatic send_bit(input bit b, input bit d);
        bus.sin_i       = b;
        bus.dir_i       = d;
        bus.sin_valid_i = 1'b1;
        step();
        bus.sin_valid_i = 1'b0;
    endtask

    task automatic consume();
        bus.out_ready_i = 1'b1;
        step();
        bus.out_ready_i = 1'b0;
    endtask

    task automatic do_reset();
        bus.sin_i       = 1'b0;
        bus.sin_valid_i = 1'b0;
        bus.dir_i       = 1'b0;
        bus.clear_i     = 1'b0;
        bus.out_ready_i = 1'b0;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [W-1:0] sh;

    initial begin
        do_reset();
        chk("rst_out",     int'(bus.out_o),       0);
        chk("rst_valid",   int'(bus.out_valid_o), 0);
        chk("rst_busy",    int'(bus.busy_o),      0);
        chk("rst_overrun", int'(bus.overrun_o),   0);

        // MSB-first back-to-back, held without ready
        send_bit(1'b1, 1'b0);
        chk("t1_busy_after_first", int'(bus.busy_o), 1);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        chk("t1_out",   int'(bus.out_o),       32'hB);
        chk("t1_valid", int'(bus.out_valid_o), 1);
        chk("t1_busy",  int'(bus.busy_o),      0);
        repeat (5) step();
        chk("t1_out_held", int'(bus.out_o), 32'hB);
        consume();

        // LSB-first with gaps; DIR toggled mid-word must not matter
        send_bit(1'b1, 1'b1); step(); step();
        send_bit(1'b1, 1'b1); step();
        bus.dir_i = 1'b0;     step();
        send_bit(1'b0, 1'b0); step(); step();
        chk("t2_not_yet_valid", int'(bus.out_valid_o), 0);
        send_bit(1'b1, 1'b0);
        chk("t2_out", int'(bus.out_o), 32'hB);
        consume();

        // Overrun while held, then clear
        send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0);
        chk("t3_out", int'(bus.out_o), 32'h6);
        send_bit(1'b1, 1'b0);
        chk("t3_overrun", int'(bus.overrun_o), 1);
        chk("t3_out_kept", int'(bus.out_o), 32'h6);
        bus.clear_i = 1'b1; step(); bus.clear_i = 1'b0;
        chk("t3_clr_overrun", int'(bus.overrun_o),   0);
        chk("t3_clr_valid",   int'(bus.out_valid_o), 0);

        // Consume and accept first bit of next word on the same edge
        repeat (4) send_bit(1'b1, 1'b0);
        bus.out_ready_i = 1'b1;
        send_bit(1'b1, 1'b0);
        bus.out_ready_i = 1'b0;
        chk("t4_valid_dropped", int'(bus.out_valid_o), 0);
        chk("t4_busy",          int'(bus.busy_o),      1);
        chk("t4_overrun",       int'(bus.overrun_o),   0);
        send_bit(1'b0, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
        chk("t4_out", int'(bus.out_o), 32'h9);
        consume();

        // Asynchronous reset mid-word
        send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0);
        @(posedge clk); model_edge();
        #3 rst_n = 1'b0;
        model_reset();
        #1;
        chk("t5_out",   int'(bus.out_o),       0);
        chk("t5_valid", int'(bus.out_valid_o), 0);
        chk("t5_busy",  int'(bus.busy_o),      0);
        #1 rst_n = 1'b1;
        send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0);
        chk("t5_out_after", int'(bus.out_o), 32'h7);
        consume();

        // Loopback from a left-shifting then right-shifting source
        sh = 4'b1101;
        for (int i = 0; i < int'(W); i++) begin
            send_bit(sh[W-1], 1'b0);
            sh = sh << 1;
        end
        chk("t6_lsh_out", int'(bus.out_o), 32'hD);
        consume();
        sh = 4'b1101;
        for (int i = 0; i < int'(W); i++) begin
            send_bit(sh[0], 1'b1);
            sh = sh >> 1;
        end
        chk("t6_rsh_out", int'(bus.out_o), 32'hD);
        consume();

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            bus.sin_i       = 1'($urandom_range(1));
            bus.dir_i       = 1'($urandom_range(1));
            bus.sin_valid_i = ($urandom_range(99) < 60);
            bus.out_ready_i = ($urandom_range(99) < 30);
            bus.clear_i     = ($urandom_range(99) < 2);
            step();
        end
        bus.sin_valid_i = 1'b0;
        bus.out_ready_i = 1'b0;
        bus.clear_i     = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
